imem_program_loader: RTL
========================

# imem_program_loader

Writer-side counterpart to the fetch path: accepts a stream of (opcode, operand) pairs over a valid/ready handshake, checks each opcode against the ISA instruction map, packs it into a 9-bit instruction word, and writes it into instruction memory at consecutive addresses. It sits between the test/boot host and the instruction memory write port. The processor core then fetches and decodes the loaded program unchanged.

## Interface

Parameters:
- `AW`, 8, instruction-memory address width; addresses wrap modulo 2^AW.
- `IW`, 9, instruction word width: opcode[3:0] in bits [8:5], operand[4:0] in bits [4:0].

Ports:
- `CLK`  in  1  single clock; all state changes on rising edge.
- `reset_n`  in  1  reset, asynchronous and active-low.
- `start`  in  1  begin a load; sampled only in IDLE.
- `base_addr`  in  AW  first write address; latched on accepted `start`.
- `length`  in  AW  number of words to load; latched on accepted `start`.
- `in_valid`  in  1  host has a word on `in_op`/`in_arg`.
- `in_op`  in  4  opcode; legal values 4'b0000 (Mov) through 4'b1110 (setBranch).
- `in_arg`  in  5  operand field, passed through unchanged.
- `in_ready`  out  1  loader accepts a word this cycle.
- `imem_we`  out  1  instruction-memory write enable.
- `imem_addr`  out  AW  write address.
- `imem_wdata`  out  IW  packed word {in_op, in_arg}.
- `busy`  out  1  high in LOAD.
- `done`  out  1  one-cycle pulse on successful completion.
- `err`  out  1  sticky illegal-opcode flag; cleared by the next accepted `start`.
- `err_addr`  out  AW  address at which the illegal opcode arrived.

## Operation

- States: IDLE, LOAD.
- IDLE:
  - `in_ready`=0, `busy`=0.
  - On `start`=1: latch `base_addr` into the address counter and `length` into the remaining counter, and clear `err`/`err_addr`.
  - If `length`≠0, go to LOAD.
  - If `length`=0, stay in IDLE and pulse `done` the next cycle; no writes occur.
- LOAD:
  - `in_ready`=1 and `busy`=1.
  - A transfer occurs on a cycle where `in_valid`&&`in_ready`.
  - `start` is ignored; it has no effect on counters or on `err`.
- Legal transfer (`in_op`≠4'b1111):
  - Register the write: `imem_addr`←addr, `imem_wdata`←{in_op,in_arg}, `imem_we`←1.
  - addr←addr+1 (mod 2^AW; 8'hFF wraps to 8'h00); remaining←remaining−1.
  - If remaining was 1, go to IDLE and pulse `done` coincident with the final write.
- Illegal transfer (`in_op`=4'b1111):
  - The word is consumed but not written.
  - `err`←1, `err_addr`←current addr, go to IDLE; `done` is not pulsed.
  - The load is aborted; words already written remain in memory.
- `imem_we` is high only in the cycle after a legal transfer; otherwise 0. `imem_addr`/`imem_wdata` hold their last values when `imem_we`=0.
- No opcode interpretation beyond the legality check: branch, memory and arithmetic opcodes are packed identically.

## Timing

- Reset values (async on `reset_n`=0): state IDLE; `in_ready`=0, `busy`=0, `imem_we`=0, `imem_addr`=0, `imem_wdata`=0, `done`=0, `err`=0, `err_addr`=0; counters 0.
- Reset mid-load: the load is abandoned immediately. No further writes occur, and `imem_we` drops asynchronously.
- `start` accepted at edge t gives `in_ready`=1 from cycle t+1.
- Transfer at edge t gives `imem_we`=1 during cycle t+1 (latency 1).
- Back-to-back transfers yield one write per cycle; full throughput with no bubbles.
- Final transfer at edge t: `done`=1 and the last `imem_we`=1 both during cycle t+1, `in_ready`=0 from cycle t+1, and a new `start` is accepted at edge t+1.
- `length`=0: `start` at edge t gives `done`=1 during cycle t+1.
- `in_valid` gaps simply stall; there is no timeout.
- `in_op`/`in_arg` are sampled only on transfer cycles.

## Test plan

- Reset check: assert `reset_n`=0 mid-LOAD after 2 of 4 words → all outputs at reset values next cycle, no further `imem_we`, and the following load works normally.
- Basic load: `start`, `base_addr`=8'h10, `length`=3; words (0110,00011), (1010,11111), (1110,00001) back-to-back → writes 9'h0C3@8'h10, 9'h15F@8'h11, 9'h1C1@8'h12 on consecutive cycles; `done` with the last write.
- Wrap and stall: `base_addr`=8'hFE, `length`=3, `in_valid` toggled 1,0,0,1,0,1 → writes at 8'hFE, 8'hFF, 8'h00 only on the cycles after transfers; `busy` stays high throughout.
- Illegal opcode: `length`=4; second word `in_op`=4'b1111 at addr 8'h21 (base 8'h20) → one write at 8'h20, `err`=1, `err_addr`=8'h21, no `done`, state IDLE. A new `start` clears `err`.
- Zero length plus ignored start: `length`=0 → `done` pulse, no `imem_we`. During a 2-word load, pulse `start` with `base_addr`=8'h80 → ignored, writes continue at the original addresses.

Source files
------------

// File: rtl/imem_program_loader.sv
// Packs (opcode, operand) pairs from a valid/ready stream into 9-bit words and
// writes them to instruction memory at consecutive addresses, aborting on opcode 4'b1111.
module imem_program_loader #(
  parameter int AW = 8,
  parameter int IW = 9
) (
  input  logic          CLK,
  input  logic          reset_n,
  input  logic          start,
  input  logic [AW-1:0] base_addr,
  input  logic [AW-1:0] length,
  input  logic          in_valid,
  input  logic [3:0]    in_op,
  input  logic [4:0]    in_arg,
  output logic          in_ready,
  output logic          imem_we,
  output logic [AW-1:0] imem_addr,
  output logic [IW-1:0] imem_wdata,
  output logic          busy,
  output logic          done,
  output logic          err,
  output logic [AW-1:0] err_addr
);

  typedef enum logic {IDLE, LOAD} state_e;

  localparam logic [3:0] OP_ILLEGAL = 4'b1111;

  state_e        state_q, state_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [AW-1:0] rem_q, rem_d;
  logic          we_q, we_d;
  logic [AW-1:0] waddr_q, waddr_d;
  logic [IW-1:0] wdata_q, wdata_d;
  logic          done_q, done_d;
  logic          err_q, err_d;
  logic [AW-1:0] err_addr_q, err_addr_d;

  // Handshake and status derive from the state register alone, so reset drops them at once.
  assign in_ready   = (state_q == LOAD);
  assign busy       = (state_q == LOAD);
  assign imem_we    = we_q;
  assign imem_addr  = waddr_q;
  assign imem_wdata = wdata_q;
  assign done       = done_q;
  assign err        = err_q;
  assign err_addr   = err_addr_q;

  always_comb begin
    // NOTE: every next-state signal gets a default first so no path can infer a latch.
    state_d    = state_q;
    addr_d     = addr_q;
    rem_d      = rem_q;
    we_d       = 1'b0;
    waddr_d    = waddr_q;
    wdata_d    = wdata_q;
    done_d     = 1'b0;
    err_d      = err_q;
    err_addr_d = err_addr_q;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          addr_d     = base_addr;
          rem_d      = length;
          err_d      = 1'b0;
          err_addr_d = '0;
          if (length != '0) state_d = LOAD;
          else              done_d  = 1'b1;
        end
      end
      LOAD: begin
        if (in_valid) begin
          if (in_op != OP_ILLEGAL) begin
            we_d    = 1'b1;
            waddr_d = addr_q;
            wdata_d = {in_op, in_arg};
            addr_d  = addr_q + 1'b1;
            rem_d   = rem_q - 1'b1;
            if (rem_q == AW'(1)) begin
              state_d = IDLE;
              done_d  = 1'b1;
            end
          end else begin
            // Aborted load: the word is consumed, nothing is written, no done.
            err_d      = 1'b1;
            err_addr_d = addr_q;
            state_d    = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge CLK or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      addr_q     <= '0;
      rem_q      <= '0;
      we_q       <= 1'b0;
      waddr_q    <= '0;
      wdata_q    <= '0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      err_addr_q <= '0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      rem_q      <= rem_d;
      we_q       <= we_d;
      waddr_q    <= waddr_d;
      wdata_q    <= wdata_d;
      done_q     <= done_d;
      err_q      <= err_d;
      err_addr_q <= err_addr_d;
    end
  end

endmodule
